// File: rtl/rank_result_capture_pkg.sv
// rank_result_capture_pkg
// Definitions shared by the capture stage and its neighbours (filter, display):
//   - cap_state_t : control states of the capture stage
//   - DEFAULT_DATA_BITS / DEFAULT_ADDR_BITS : default result and buffer widths
package rank_result_capture_pkg;

  localparam int DEFAULT_DATA_BITS = 8;
  localparam int DEFAULT_ADDR_BITS = 8;

  typedef enum logic [1:0] {
    WARMUP  = 2'd0,
    CAPTURE = 2'd1,
    BROWSE  = 2'd2
  } cap_state_t;

endpackage

// File: rtl/rank_result_capture_ram.sv
// capture_ram
// Simple dual-port result buffer, 2**ADDR_BITS x DATA_BITS.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset (clears the read register only)
//   wr_en    write strobe
//   wr_addr  write address
//   wr_data  write data
//   rd_addr  read address, sampled every cycle
//   rd_data  registered read data; a same-cycle write to rd_addr returns old data
module capture_ram
  import rank_result_capture_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [DATA_BITS-1:0] mem [DEPTH];

  // Write port; contents are deliberately never cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; the non-blocking update gives read-before-write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/rank_result_capture.sv
// rank_result_capture
// Drops the rank-order filter's warm-up samples, stores NUM_CAPTURE results,
// then lets an operator browse them with up/down buttons.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   in_data carries a new filter result
//   in_data    filter result
//   step_up    debounced level, each rising edge advances the browse index
//   step_down  debounced level, each rising edge retreats the browse index
//   done       capture complete, browsing enabled
//   rd_ptr     current browse index
//   rd_data    buffer content at rd_ptr (one cycle behind rd_ptr)
//   wr_count   number of results stored so far
module rank_result_capture
  import rank_result_capture_pkg::*;
#(
  parameter int DATA_BITS   = DEFAULT_DATA_BITS,
  parameter int ADDR_BITS   = DEFAULT_ADDR_BITS,
  parameter int LATENCY     = 0,
  parameter int NUM_CAPTURE = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 step_up,
  input  logic                 step_down,
  output logic                 done,
  output logic [ADDR_BITS-1:0] rd_ptr,
  output logic [DATA_BITS-1:0] rd_data,
  output logic [ADDR_BITS:0]   wr_count
);

  // skip_cnt must be able to hold LATENCY; keep at least one bit for LATENCY == 0.
  localparam int SKIP_BITS = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  localparam logic [SKIP_BITS-1:0] SKIP_LAST = (LATENCY > 0) ? SKIP_BITS'(LATENCY - 1) : '0;
  localparam logic [SKIP_BITS-1:0] SKIP_ONE  = SKIP_BITS'(1);
  localparam logic [ADDR_BITS:0]   WR_LAST   = (ADDR_BITS + 1)'(NUM_CAPTURE - 1);
  localparam logic [ADDR_BITS:0]   WR_ONE    = (ADDR_BITS + 1)'(1);
  localparam logic [ADDR_BITS-1:0] PTR_LAST  = ADDR_BITS'(NUM_CAPTURE - 1);
  localparam logic [ADDR_BITS-1:0] PTR_ONE   = ADDR_BITS'(1);
  localparam cap_state_t           INIT_STATE = (LATENCY == 0) ? CAPTURE : WARMUP;

  cap_state_t           state;
  logic [SKIP_BITS-1:0] skip_cnt;
  logic                 up_prev;
  logic                 down_prev;
  logic                 up_rise;
  logic                 down_rise;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_addr;

  // Edge detection and buffer write strobe.
  always_comb begin
    up_rise   = step_up & ~up_prev;
    down_rise = step_down & ~down_prev;
    wr_addr   = wr_count[ADDR_BITS-1:0];
    if (!rst && (state == CAPTURE) && in_valid) begin
      wr_en = 1'b1;
    end else begin
      wr_en = 1'b0;
    end
  end

  // Control FSM with warm-up counter, write counter and browse pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT_STATE;
      skip_cnt  <= '0;
      wr_count  <= '0;
      rd_ptr    <= '0;
      done      <= 1'b0;
      up_prev   <= 1'b0;
      down_prev <= 1'b0;
    end else begin
      // History tracks the levels in every state, so a button already held
      // when BROWSE is entered produces no move.
      up_prev   <= step_up;
      down_prev <= step_down;
      case (state)
        WARMUP: begin
          if (in_valid) begin
            skip_cnt <= skip_cnt + SKIP_ONE;
            if (skip_cnt == SKIP_LAST) begin
              state <= CAPTURE;
            end
          end
        end
        CAPTURE: begin
          if (in_valid) begin
            wr_count <= wr_count + WR_ONE;
            if (wr_count == WR_LAST) begin
              state <= BROWSE;
              done  <= 1'b1;
            end
          end
        end
        BROWSE: begin
          // Opposite rises in the same cycle cancel out.
          if (up_rise && !down_rise) begin
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
          end else if (down_rise && !up_rise) begin
            rd_ptr <= (rd_ptr == '0) ? PTR_LAST : rd_ptr - PTR_ONE;
          end
        end
        default: begin
          state <= INIT_STATE;
        end
      endcase
    end
  end

  capture_ram #(
    .DATA_BITS (DATA_BITS),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (in_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_rank_result_capture.sv
// tb_rank_result_capture
// Directed bench for rank_result_capture with LATENCY=3, NUM_CAPTURE=5, ADDR_BITS=3.
// Inputs change 1ns after each rising edge; outputs are sampled at that same point.
module tb_rank_result_capture;

  localparam int DATA_BITS   = 8;
  localparam int ADDR_BITS   = 3;
  localparam int LATENCY     = 3;
  localparam int NUM_CAPTURE = 5;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic [DATA_BITS-1:0] in_data;
  logic                 step_up;
  logic                 step_down;
  logic                 done;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [DATA_BITS-1:0] rd_data;
  logic [ADDR_BITS:0]   wr_count;

  int total = 0;
  int bad   = 0;

  rank_result_capture #(
    .DATA_BITS   (DATA_BITS),
    .ADDR_BITS   (ADDR_BITS),
    .LATENCY     (LATENCY),
    .NUM_CAPTURE (NUM_CAPTURE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .step_up   (step_up),
    .step_down (step_down),
    .done      (done),
    .rd_ptr    (rd_ptr),
    .rd_data   (rd_data),
    .wr_count  (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // One 3-high / 3-low press of step_up; checks the move and the data behind it.
  task automatic browse_up(input int exp_ptr, input int exp_data);
    step_up = 1'b1;
    tick();
    check("up_ptr", int'(rd_ptr), exp_ptr);
    tick();
    check("up_data", int'(rd_data), exp_data);
    tick();
    step_up = 1'b0;
    repeat (3) tick();
  endtask

  // Continuous stream base..base+7; the first LATENCY samples are dropped.
  task automatic stream(input int base);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = DATA_BITS'(base + i);
      tick();
      check("wr_count", int'(wr_count), (i < LATENCY) ? 0 : i - LATENCY + 1);
      check("done", int'(done), (i == 7) ? 1 : 0);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; step_up = 1'b0; step_down = 1'b0;

    // Reset state
    tick();
    check("rst_done", int'(done), 0);
    check("rst_wr_count", int'(wr_count), 0);
    check("rst_rd_ptr", int'(rd_ptr), 0);
    check("rst_rd_data", int'(rd_data), 0);
    rst = 1'b0;

    // Warm-up and continuous capture of 10..17
    stream(10);
    check("cap_rd_ptr", int'(rd_ptr), 0);
    check("cap_rd_data", int'(rd_data), 13);
    tick();
    check("cap_rd_data2", int'(rd_data), 13);

    // Browse up with wrap
    browse_up(1, 14);
    browse_up(2, 15);
    browse_up(3, 16);
    browse_up(4, 17);
    browse_up(0, 13);

    // Long hold of step_down gives one move with wrap
    step_down = 1'b1;
    tick();
    check("dn_ptr", int'(rd_ptr), 4);
    repeat (9) tick();
    check("dn_hold_ptr", int'(rd_ptr), 4);
    check("dn_hold_data", int'(rd_data), 17);
    step_down = 1'b0;
    tick();

    // Simultaneous rises cancel
    step_up = 1'b1; step_down = 1'b1;
    tick();
    check("both_ptr", int'(rd_ptr), 4);
    tick();
    step_up = 1'b0; step_down = 1'b0;
    tick();

    // in_valid ignored in BROWSE
    in_valid = 1'b1; in_data = 8'd99;
    tick();
    in_valid = 1'b0;
    tick();
    check("browse_wr_count", int'(wr_count), 5);
    check("browse_data", int'(rd_data), 17);

    // Stalled stream with an early step_up press during capture
    do_reset();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = DATA_BITS'(10 + i);
      tick();
      in_valid = 1'b0;
      if (i == 7) begin
        check("stall_done8", int'(done), 1);
      end else begin
        check("stall_done", int'(done), 0);
      end
      step_up = (i == 4) ? 1'b1 : 1'b0;
      tick();
      step_up = 1'b0;
      tick();
    end
    check("stall_wr_count", int'(wr_count), 5);
    check("early_ptr", int'(rd_ptr), 0);
    check("stall_data0", int'(rd_data), 13);
    browse_up(1, 14);
    browse_up(2, 15);
    browse_up(3, 16);
    browse_up(4, 17);

    // Reset mid-capture, then fresh stream 20..27
    do_reset();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = DATA_BITS'(20 + i);
      tick();
    end
    in_valid = 1'b0;
    check("mid_wr_count", int'(wr_count), 2);
    do_reset();
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_wr_count", int'(wr_count), 0);
    stream(20);
    check("re_rd_ptr", int'(rd_ptr), 0);
    check("re_rd_data", int'(rd_data), 23);
    browse_up(1, 24);
    browse_up(2, 25);
    browse_up(3, 26);
    browse_up(4, 27);
    browse_up(0, 23);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
